// File: rtl/carrier_sense_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : carrier_sense_detect_pkg
// Description : Shared register offsets, FSM state encoding and helpers for
//               the carrier-sense detector.
// Revision    : 1.0 - initial release
// ============================================================================
package carrier_sense_detect_pkg;

  localparam logic [7:0] CS_REG_THRESH  = 8'd0;
  localparam logic [7:0] CS_REG_HOLDOFF = 8'd1;
  localparam logic [7:0] CS_REG_CTRL    = 8'd2;

  localparam logic [3:0] CS_KMAX = 4'd8;

  typedef enum logic [1:0] {
    CS_IDLE    = 2'd0,
    CS_BUSY    = 2'd1,
    CS_HOLDOFF = 2'd2
  } cs_state_e;

  // Clamp the averaging shift so the EMA never shifts by more than CS_KMAX.
  function automatic logic [3:0] cs_sat_k(input logic [3:0] k);
    return (k > CS_KMAX) ? CS_KMAX : k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/carrier_sense_detect_power_est.sv
`default_nettype none
// ============================================================================
// Module      : carrier_power_est
// Description : Stages 1-3 of the carrier detector: I/Q squaring, power sum
//               and programmable exponential moving average.
// Revision    : 1.0 - initial release
// ============================================================================
module carrier_power_est
  import carrier_sense_detect_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] sample_i,
  input  logic        strobe_i,
  input  logic [3:0]  k_i,
  input  logic        clear_i,
  output logic [31:0] avg_o,
  output logic        avg_valid_o
);

  logic [31:0] w_i_ext;
  logic [31:0] w_q_ext;
  logic [31:0] isq_q;
  logic [31:0] qsq_q;
  logic [31:0] pwr_q;
  logic [31:0] avg_q;
  logic        v1_q;
  logic        v2_q;
  logic        v3_q;
  logic [32:0] avg_d;
  logic        w_unused_msb;

  // Sign-extend so the low 32 bits of the product are the exact square.
  assign w_i_ext = {{16{sample_i[31]}}, sample_i[31:16]};
  assign w_q_ext = {{16{sample_i[15]}}, sample_i[15:0]};

  // avg - (avg>>k) + (pwr>>k); bounded by max(pwr) so bit 32 is never needed.
  assign avg_d = {1'b0, avg_q} - {1'b0, (avg_q >> k_i)} + {1'b0, (pwr_q >> k_i)};
  assign w_unused_msb = avg_d[32];

  // Valid pipeline and EMA state; clear/disable flushes samples in flight.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      avg_q <= '0;
    end else begin
      v1_q <= strobe_i;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (v2_q) begin
        avg_q <= avg_d[31:0];
      end
    end
  end

  // Datapath registers: squares on stage 1, power sum on stage 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      isq_q <= '0;
      qsq_q <= '0;
      pwr_q <= '0;
    end else begin
      if (strobe_i) begin
        isq_q <= w_i_ext * w_i_ext;
        qsq_q <= w_q_ext * w_q_ext;
      end
      if (v1_q) begin
        pwr_q <= isq_q + qsq_q;
      end
    end
  end

  assign avg_o       = avg_q;
  assign avg_valid_o = v3_q;

endmodule
`default_nettype wire

// File: rtl/setting_reg.sv
`default_nettype none
// ============================================================================
// Module      : setting_reg
// Description : Single settings-bus register, loaded when the bus address
//               matches MY_ADDR.
// Revision    : 1.0 - initial release
// ============================================================================
module setting_reg #(
  parameter logic [7:0]       MY_ADDR  = 8'd0,
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] AT_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe_i,
  input  logic [7:0]       addr_i,
  input  logic [31:0]      data_i,
  output logic [WIDTH-1:0] out_o
);

  logic [WIDTH-1:0] out_q;

  // Capture bus data on an address match.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= AT_RESET;
    end else if (strobe_i && (addr_i == MY_ADDR)) begin
      out_q <= data_i[WIDTH-1:0];
    end
  end

  assign out_o = out_q;

endmodule
`default_nettype wire

// File: rtl/carrier_sense_detect.sv
`default_nettype none
// ============================================================================
// Module      : carrier_sense_detect
// Description : Carrier detector for listen-before-talk. Compares averaged
//               RX power to a threshold and runs a busy/hold-off FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module carrier_sense_detect
  import carrier_sense_detect_pkg::*;
#(
  parameter logic [7:0] BASE = 8'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        run_rx,
  input  logic [31:0] sample,
  input  logic        strobe,
  output logic        carrier_present,
  output logic [31:0] carrier_present_nextcount,
  output logic [31:0] debug
);

  logic [31:0] w_threshold;
  logic [31:0] w_holdoff;
  logic [31:0] w_ctrl;
  logic [26:0] w_unused_ctrl;
  logic        w_enable;
  logic [3:0]  w_k;
  logic        w_ctrl_wr;
  logic        w_clear;
  logic [31:0] w_avg;
  logic        w_avg_valid;
  logic        w_above;

  cs_state_e   state_q;
  cs_state_e   state_d;
  logic [31:0] nextcount_q;
  logic [31:0] nextcount_d;

  setting_reg #(.MY_ADDR(BASE + CS_REG_THRESH), .WIDTH(32)) u_sr_thresh (
    .clk(clk), .reset(reset), .strobe_i(set_stb), .addr_i(set_addr),
    .data_i(set_data), .out_o(w_threshold)
  );

  setting_reg #(.MY_ADDR(BASE + CS_REG_HOLDOFF), .WIDTH(32)) u_sr_holdoff (
    .clk(clk), .reset(reset), .strobe_i(set_stb), .addr_i(set_addr),
    .data_i(set_data), .out_o(w_holdoff)
  );

  setting_reg #(.MY_ADDR(BASE + CS_REG_CTRL), .WIDTH(32)) u_sr_ctrl (
    .clk(clk), .reset(reset), .strobe_i(set_stb), .addr_i(set_addr),
    .data_i(set_data), .out_o(w_ctrl)
  );

  assign w_enable      = w_ctrl[4];
  assign w_k           = cs_sat_k(w_ctrl[3:0]);
  assign w_unused_ctrl = w_ctrl[31:5];

  // The clear acts on the write edge itself, so a strobe on that cycle is lost.
  assign w_ctrl_wr = set_stb && (set_addr == (BASE + CS_REG_CTRL));
  assign w_clear   = w_ctrl_wr || !run_rx || !w_enable;

  carrier_power_est u_power_est (
    .clk         (clk),
    .reset       (reset),
    .sample_i    (sample),
    .strobe_i    (strobe),
    .k_i         (w_k),
    .clear_i     (w_clear),
    .avg_o       (w_avg),
    .avg_valid_o (w_avg_valid)
  );

  assign w_above = (w_avg > w_threshold);

  // State and hold-off counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CS_IDLE;
      nextcount_q <= '0;
    end else begin
      state_q     <= state_d;
      nextcount_q <= nextcount_d;
    end
  end

  // Next-state logic, evaluated only when an averaged sample reaches stage 4.
  always_comb begin
    state_d     = state_q;
    nextcount_d = nextcount_q;
    if (w_clear) begin
      state_d     = CS_IDLE;
      nextcount_d = '0;
    end else if (w_avg_valid) begin
      case (state_q)
        CS_IDLE: begin
          if (w_above) begin
            state_d     = CS_BUSY;
            nextcount_d = w_holdoff;
          end else begin
            nextcount_d = '0;
          end
        end
        CS_BUSY: begin
          if (w_above) begin
            nextcount_d = w_holdoff;
          end else if (w_holdoff == 32'd0) begin
            state_d     = CS_IDLE;
            nextcount_d = '0;
          end else begin
            state_d     = CS_HOLDOFF;
            nextcount_d = w_holdoff;
          end
        end
        CS_HOLDOFF: begin
          if (w_above) begin
            state_d     = CS_BUSY;
            nextcount_d = w_holdoff;
          end else if (nextcount_q == 32'd1) begin
            state_d     = CS_IDLE;
            nextcount_d = '0;
          end else begin
            nextcount_d = nextcount_q - 32'd1;
          end
        end
        default: begin
          state_d     = CS_IDLE;
          nextcount_d = '0;
        end
      endcase
    end
  end

  assign carrier_present           = (state_q != CS_IDLE);
  assign carrier_present_nextcount = nextcount_q;
  assign debug                     = {state_q, w_above, w_avg_valid, w_avg[31:4]};

endmodule
`default_nettype wire

// File: tb/tb_carrier_sense_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_carrier_sense_detect
// Description : Directed self-checking bench for carrier_sense_detect.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_carrier_sense_detect;

  localparam logic [7:0] BASE = 8'h40;
  localparam logic [7:0] A_THR = BASE + 8'd0;
  localparam logic [7:0] A_HOLD = BASE + 8'd1;
  localparam logic [7:0] A_CTRL = BASE + 8'd2;

  logic        clk;
  logic        reset;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        run_rx;
  logic [31:0] sample;
  logic        strobe;
  logic        carrier_present;
  logic [31:0] carrier_present_nextcount;
  logic [31:0] debug;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
    logic [31:0] thr;
    logic [31:0] pwr;
    logic        cp;
  } vec_t;

  vec_t vecs[7];

  carrier_sense_detect #(.BASE(BASE)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .set_stb                   (set_stb),
    .set_addr                  (set_addr),
    .set_data                  (set_data),
    .run_rx                    (run_rx),
    .sample                    (sample),
    .strobe                    (strobe),
    .carrier_present           (carrier_present),
    .carrier_present_nextcount (carrier_present_nextcount),
    .debug                     (debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    tick(1);
    set_stb  = 1'b0;
  endtask

  task automatic send(input logic [15:0] i, input logic [15:0] q);
    sample = {i, q};
    strobe = 1'b1;
    tick(1);
    strobe = 1'b0;
  endtask

  initial begin
    logic [31:0] e;
    logic [31:0] ema [5];

    vecs[0] = '{16'h1000, 16'h0000, 32'h00FFFFFF, 32'h01000000, 1'b1};
    vecs[1] = '{16'h8000, 16'h8000, 32'h7FFFFFFF, 32'h80000000, 1'b1};
    vecs[2] = '{16'h0100, 16'h0100, 32'h00020000, 32'h00020000, 1'b0};
    vecs[3] = '{16'h0003, 16'h0004, 32'h00000018, 32'h00000019, 1'b1};
    vecs[4] = '{16'hFFFB, 16'h7FFF, 32'hFFFFFFFF, 32'h3FFF001A, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h7FFF, 32'h7FFE0001, 32'h7FFE0002, 1'b1};
    ema[0] = 32'h100; ema[1] = 32'h1C0; ema[2] = 32'h250;
    ema[3] = 32'h2BC; ema[4] = 32'h30D;

    reset = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0;
    run_rx = 1'b1; sample = '0; strobe = 1'b0;
    tick(3);
    chk("reset_cp", {31'd0, carrier_present}, 32'd0);
    chk("reset_nc", carrier_present_nextcount, 32'd0);
    chk("reset_dbg", debug, 32'd0);
    reset = 1'b0;
    tick(1);

    // First-carrier latency with full-rate strobes
    wr(A_HOLD, 32'd5);
    wr(A_THR, 32'h00FFFFFF);
    wr(A_CTRL, 32'h10);
    sample = {16'h1000, 16'h0000};
    strobe = 1'b1;
    for (int m = 1; m <= 4; m++) begin
      tick(1);
      if (m == 3) begin
        chk("lat_cp_m3", {31'd0, carrier_present}, 32'd0);
        chk("lat_avg_m3", {4'd0, debug[27:0]}, 32'h00100000);
      end
      if (m == 4) begin
        chk("lat_cp_m4", {31'd0, carrier_present}, 32'd1);
        chk("lat_nc_m4", carrier_present_nextcount, 32'd5);
      end
    end
    strobe = 1'b0;
    tick(4);

    // Hold-off countdown
    for (int s = 0; s < 5; s++) begin
      send(16'h0, 16'h0);
      tick(3);
      chk("hold_nc", carrier_present_nextcount, 32'(5 - s));
      chk("hold_cp", {31'd0, carrier_present}, 32'd1);
    end
    send(16'h0, 16'h0);
    tick(3);
    chk("hold_end_cp", {31'd0, carrier_present}, 32'd0);
    chk("hold_end_nc", carrier_present_nextcount, 32'd0);

    // Re-trigger from HOLDOFF at cnt=3
    send(16'h1000, 16'h0);
    tick(3);
    chk("retrig_busy_nc", carrier_present_nextcount, 32'd5);
    for (int s = 0; s < 3; s++) begin
      send(16'h0, 16'h0);
      tick(3);
    end
    chk("retrig_cnt3", carrier_present_nextcount, 32'd3);
    send(16'h1000, 16'h0);
    tick(3);
    chk("retrig_nc", carrier_present_nextcount, 32'd5);
    chk("retrig_state", {30'd0, debug[31:30]}, 32'd1);

    // Table of single-sample vectors, k=0
    wr(A_HOLD, 32'd3);
    for (int v = 0; v < 7; v++) begin
      wr(A_THR, vecs[v].thr);
      wr(A_CTRL, 32'h10);
      send(vecs[v].i, vecs[v].q);
      tick(3);
      e = vecs[v].pwr;
      chk($sformatf("vec%0d_avg", v), {4'd0, debug[27:0]}, {4'd0, e[31:4]});
      chk($sformatf("vec%0d_above", v), {31'd0, debug[29]}, {31'd0, vecs[v].cp});
      chk($sformatf("vec%0d_cp", v), {31'd0, carrier_present}, {31'd0, vecs[v].cp});
      chk($sformatf("vec%0d_nc", v), carrier_present_nextcount, vecs[v].cp ? 32'd3 : 32'd0);
    end

    // EMA with k=2 at full rate
    wr(A_HOLD, 32'd5);
    wr(A_THR, 32'h300);
    wr(A_CTRL, 32'h12);
    sample = {16'h0020, 16'h0000};
    strobe = 1'b1;
    for (int m = 1; m <= 8; m++) begin
      tick(1);
      if (m == 5) strobe = 1'b0;
      if (m >= 3 && m <= 7) begin
        e = ema[m-3];
        chk($sformatf("ema_avg_m%0d", m), {4'd0, debug[27:0]}, {4'd0, e[31:4]});
      end
      if (m == 7) chk("ema_cp_m7", {31'd0, carrier_present}, 32'd0);
      if (m == 8) chk("ema_cp_m8", {31'd0, carrier_present}, 32'd1);
    end

    // Control write mid-BUSY with a strobe on the same cycle
    sample = {16'h1000, 16'h0000};
    strobe = 1'b1;
    set_stb = 1'b1; set_addr = A_CTRL; set_data = 32'h10;
    tick(1);
    strobe = 1'b0; set_stb = 1'b0;
    chk("clr_cp", {31'd0, carrier_present}, 32'd0);
    chk("clr_nc", carrier_present_nextcount, 32'd0);
    tick(5);
    chk("clr_drop_cp", {31'd0, carrier_present}, 32'd0);
    chk("clr_drop_avg", {4'd0, debug[27:0]}, 32'd0);

    // run_rx falling with samples in flight
    send(16'h1000, 16'h0);
    tick(3);
    chk("rx_busy_cp", {31'd0, carrier_present}, 32'd1);
    sample = {16'h1000, 16'h0000};
    strobe = 1'b1;
    tick(1);
    run_rx = 1'b0;
    tick(1);
    chk("rx_off_cp", {31'd0, carrier_present}, 32'd0);
    chk("rx_off_nc", carrier_present_nextcount, 32'd0);
    run_rx = 1'b1;
    strobe = 1'b0;
    tick(5);
    chk("rx_drop_cp", {31'd0, carrier_present}, 32'd0);
    chk("rx_drop_avg", {4'd0, debug[27:0]}, 32'd0);

    // holdoff=0 goes straight from BUSY to IDLE
    wr(A_HOLD, 32'd0);
    send(16'h1000, 16'h0);
    tick(3);
    chk("h0_busy_cp", {31'd0, carrier_present}, 32'd1);
    chk("h0_busy_nc", carrier_present_nextcount, 32'd0);
    send(16'h0, 16'h0);
    tick(3);
    chk("h0_idle_cp", {31'd0, carrier_present}, 32'd0);
    chk("h0_idle_state", {30'd0, debug[31:30]}, 32'd0);

    // Disabled: strobes ignored
    wr(A_CTRL, 32'h00);
    send(16'h1000, 16'h0);
    tick(4);
    chk("dis_cp", {31'd0, carrier_present}, 32'd0);
    chk("dis_avg", {4'd0, debug[27:0]}, 32'd0);

    // k=15 saturates to 8
    wr(A_CTRL, 32'h1F);
    send(16'h1000, 16'h0);
    tick(3);
    chk("ksat_avg", {4'd0, debug[27:0]}, 32'h00001000);

    // Reset mid-BUSY
    wr(A_HOLD, 32'd7);
    wr(A_THR, 32'd0);
    wr(A_CTRL, 32'h10);
    send(16'h1000, 16'h0);
    tick(3);
    chk("rst_busy_nc", carrier_present_nextcount, 32'd7);
    reset = 1'b1;
    tick(1);
    chk("rst_cp", {31'd0, carrier_present}, 32'd0);
    chk("rst_nc", carrier_present_nextcount, 32'd0);
    chk("rst_dbg", debug, 32'd0);
    reset = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
